// File: rtl/input_unit_pkg.sv
// Shared flit, position and direction types for the router input stage.
// Helper functions classify flit types for packet framing.
package input_unit_pkg;

  typedef enum logic [1:0] {
    HEAD      = 2'b00,
    BODY      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type;

  localparam int FLIT_DATA_W = 32;

  typedef struct packed {
    flit_type                 ftype;
    logic [FLIT_DATA_W-1:0]   payload;
  } flit_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] z;
  } position;

  localparam int POS_W = $bits(position);

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    EAST  = 3'd1,
    WEST  = 3'd2,
    NORTH = 3'd3,
    SOUTH = 3'd4,
    UP    = 3'd5,
    DOWN  = 3'd6
  } direction;

  localparam int DIR_W = $bits(direction);

  function automatic logic is_head(
    input logic [1:0] ft
  );
    return (ft == HEAD) || (ft == HEAD_TAIL);
  endfunction

  function automatic logic is_tail(
    input logic [1:0] ft
  );
    return (ft == TAIL) || (ft == HEAD_TAIL);
  endfunction

endpackage

// File: rtl/input_unit_flit_fifo.sv
// Generic circular flit FIFO with naturally wrapping pointers.
// A push into a full buffer is taken only alongside a pop.
module flit_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          wr_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign wr_en = push && (!full || pop);
  assign dout  = mem[rd_ptr];

  // Storage array; contents are don't-care until counted in.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_unit.sv
// Router input port: flit buffer, per-packet route latch,
// credit return and sticky error reporting.
module input_unit
  import input_unit_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W+1:0] in_flit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W+1:0] out_flit,
  output logic [POS_W-1:0]  rcu_dest,
  input  logic [DIR_W-1:0]  rcu_dir,
  output logic [DIR_W-1:0]  route_dir,
  output logic              credit_out,
  output logic              err
);

  localparam logic IDLE   = 1'b0;
  localparam logic ACTIVE = 1'b1;

  logic       state;
  logic       full;
  logic       empty;
  logic       pop;
  logic       drop;
  logic       lost;
  logic       hd;
  logic       tl;
  logic [1:0] head_ft;

  flit_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W + 2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_flit),
    .dout  (out_flit),
    .full  (full),
    .empty (empty)
  );

  assign head_ft   = out_flit[DATA_W+1 -: 2];
  assign hd        = is_head(head_ft);
  assign tl        = is_tail(head_ft);
  assign rcu_dest  = out_flit[POS_W-1:0];
  assign out_valid = (state == ACTIVE) && !empty;
  assign drop      = (state == IDLE) && !empty && !hd;
  assign pop       = (out_valid && out_ready) || drop;
  assign lost      = in_valid && full && !pop;

  // Route FSM: latch direction on a head, release after the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      route_dir <= LOCAL;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (!empty && hd) begin
            state     <= ACTIVE;
            route_dir <= rcu_dir;
          end
        end
        (state == ACTIVE): begin
          if (out_valid && out_ready && tl) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One credit per freed entry, sticky error on loss or framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_out <= 1'b0;
      err        <= 1'b0;
    end else begin
      credit_out <= pop;
      err        <= err | lost | drop;
    end
  end

endmodule

// File: doc/input_unit.md
# input_unit

Per-port input stage of the 3D-mesh router, directly upstream of the route computation unit (`rcu_single`). It buffers incoming wormhole flits in a credit-managed FIFO and presents the head flit's destination to the RCU. It latches the returned direction once per packet and holds it for every flit until the tail, so downstream switch allocation sees a stable output direction.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2; equals the credits granted upstream at reset.
- `DATA_W`, 32: flit payload width; must be ≥ `$bits(position)`.
- `clk`  in  1  router clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  upstream flit present this cycle (credit-controlled, no ready).
- `in_flit`  in  `flit_t`  {`ftype[1:0]`, `payload[DATA_W-1:0]`}; HEAD/HEAD_TAIL payload LSBs carry the `position` dest.
- `out_valid`  out  1  routed flit available at the FIFO head.
- `out_ready`  in  1  downstream accepts the flit.
- `out_flit`  out  `flit_t`  the FIFO head flit.
- `rcu_dest`  out  `position`  dest field of the FIFO head payload, driven combinationally.
- `rcu_dir`  in  `direction`  combinational RCU result for `rcu_dest`.
- `route_dir`  out  `direction`  latched output direction of the current packet.
- `credit_out`  out  1  one-cycle pulse per freed entry.
- `err`  out  1  sticky error flag: overflow or protocol violation.

## Operation
- FIFO: circular buffer with `wr_ptr` and `rd_ptr` of log2(DEPTH) bits that wrap naturally, plus `count` of 0..DEPTH.
  - Enqueue when `in_valid`.
  - Pop when `out_valid && out_ready`, or on a protocol drop.
- Full-buffer enqueue:
  - If a pop happens in the same cycle: accepted, `count` unchanged.
  - Otherwise the flit is discarded and `err` is set.
- Route FSM, states IDLE and ACTIVE; reset state IDLE.
  - IDLE, `count>0`, head ftype HEAD or HEAD_TAIL: capture `route_dir <= rcu_dir` and go to ACTIVE.
  - IDLE, `count>0`, head ftype BODY or TAIL: pop and discard the flit, pulse credit, set `err`, stay IDLE.
  - ACTIVE: `out_valid = (count>0)`. A pop of TAIL or HEAD_TAIL returns to IDLE; other pops stay ACTIVE.
  - `out_valid` is 0 in IDLE.
- `route_dir` changes only on the IDLE→ACTIVE edge. It holds its value through IDLE until the next head.
- `credit_out` is registered. It is high in the cycle after any pop edge: 1 pulse per popped flit, including drops.
- `err` is cleared only by reset.
- Reset values:
  - FIFO: pointers 0, `count` 0, FSM IDLE.
  - Outputs: `route_dir` LOCAL, `credit_out` 0, `err` 0, `out_valid` 0.
  - Reset mid-packet abandons the packet; FIFO contents are invalidated.

## Timing
- Minimum latency: a HEAD written into an empty FIFO at edge E0 drives `rcu_dest` after E0. Route is captured at E1, and `out_valid` is high after E1, so in_valid → out_valid takes 2 cycles.
- BODY/TAIL flits behind an active route: `out_valid` is high the cycle after their write edge (1 cycle), with no bubble between flits of one packet.
- Back-to-back packets: after a TAIL pops at edge T, the next HEAD is captured at T+1 and output from T+1. One bubble cycle per packet.
- `rcu_dest` → `rcu_dir` is a combinational path. It must settle within one cycle together with the RCU logic.
- `out_flit` is valid only while `out_valid` is high. Downstream may hold `out_ready` high continuously.

## Structure
- `rcu.h` gains `flit_type` (HEAD=2'b00, BODY=2'b01, TAIL=2'b10, HEAD_TAIL=2'b11) and `flit_t`, alongside the existing `position` and `direction`.
- `input_unit` instantiates nothing; the RCU is a sibling wired at the router level.
- Natural sub-module: `flit_fifo`, a generic DEPTH×`flit_t` circular FIFO with count and full/empty flags. FSM, credit and error logic stay in `input_unit`.

## Test plan
- Single HEAD_TAIL, dest {1,0,0}, RCU returns EAST, `out_ready`=1 → `out_valid` 2 cycles after `in_valid`; `route_dir`=EAST; one `credit_out` pulse the cycle after the pop; FSM back in IDLE.
- 4-flit packet HEAD/BODY/BODY/TAIL, then a HEAD_TAIL to UP, `out_ready`=1 → 4 consecutive outputs with EAST held; 1 bubble; then UP; 5 credit pulses total.
- Fill DEPTH=4 with `out_ready`=0, then a 5th `in_valid` → `count`=4, 5th flit lost, `err`=1. With `out_ready` asserted and `in_valid` in the same cycle → accepted, `count` stays 4.
- BODY flit arriving while IDLE → dropped, `out_valid` never high, credit pulse issued, `err`=1.
- `rst_n` low mid-packet after 2 of 4 flits → within reset, `out_valid`=0, `route_dir`=LOCAL, `credit_out`=0, `err`=0. A new HEAD after release routes normally.
- Pointer wrap: stream 20 single-flit packets with random `out_ready` → output order equals input order; credits returned equal 20.
